astable555_core: RTL and testbench

- Fixed-point behavioural model of the 555 timer in astable mode.
- Consumes `v_control` (CONT pin voltage) from the walk-enable control-voltage stage and produces `square_wave`.
- `square_wave` is fed back into that control-voltage stage.
- Models the RC capacitor charge/discharge, the threshold and trigger comparators, the internal SR latch and the active-low RESET pin.
- Also reports the measured oscillation period in sample ticks.

---
 rtl/astable555_pkg.sv | 32 +++
 rtl/astable555_core_rc_step.sv | 41 ++++
 rtl/astable555_core.sv | 114 +++++++++++
 tb/tb_astable555_core.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/astable555_pkg.sv
// Shared types and helpers for the fixed-point 555 astable model.
// Voltages are unsigned Q4.12 words (1.0 V = VOLT_ONE).
package astable555_pkg;

  localparam int VOLT_W   = 16;
  localparam int VOLT_ONE = 4096;

  typedef enum logic {
    CHARGING    = 1'b0,
    DISCHARGING = 1'b1
  } state_e;

  // Adds a signed step to an unsigned value and clamps the result to
  // [0, maxVal]. Operands are carried in 32 bits so any word width up to
  // 31 bits can share this one helper; callers cast the result back down.
  function automatic logic [31:0] sat_add(
    input logic [31:0]        base,
    input logic signed [31:0] delta,
    input logic [31:0]        maxVal
  );
    logic signed [33:0] sum;
    sum = $signed({2'b00, base}) + 34'(delta);
    if (sum < 34'sd0) begin
      return 32'd0;
    end
    if (sum > $signed({2'b00, maxVal})) begin
      return maxVal;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/astable555_core_rc_step.sv
// One discrete step of an RC node: cap moves a fraction K (Q0.16) of the
// way toward target, never stalls while target != cap, and saturates to
// the unsigned word range. Purely combinational so other RC stages can
// reuse it with their own coefficients.
module rc_step
  import astable555_pkg::*;
#(
  parameter int W = VOLT_W
) (
  input  logic [W-1:0] target_i,
  input  logic [W-1:0] cap_i,
  input  logic [15:0]  k_i,
  output logic [W-1:0] cap_next_o
);

  localparam int          PW      = 2 * W + 2;
  localparam logic [31:0] CAP_MAX = 32'((64'd1 << W) - 64'd1);

  logic signed [W:0]    diff;
  logic signed [PW-1:0] diffExt;
  logic signed [PW-1:0] kExt;
  logic signed [PW-1:0] product;
  logic signed [PW-1:0] scaled;
  logic signed [W+1:0]  delta;

  // Scale the error by K with a flooring arithmetic shift; a step that
  // rounds to zero is bumped to +/-1 so the node always converges.
  always_comb begin
    diff    = $signed({1'b0, target_i}) - $signed({1'b0, cap_i});
    diffExt = PW'(diff);
    kExt    = PW'($signed({1'b0, k_i}));
    product = diffExt * kExt;
    scaled  = product >>> 16;
    delta   = (W+2)'(scaled);
    if (scaled == '0 && diff != '0) begin
      delta = diff[W] ? '1 : (W+2)'(1);
    end
    cap_next_o = W'(sat_add(32'(cap_i), 32'(delta), CAP_MAX));
  end

endmodule

// File: rtl/astable555_core.sv
// Behavioural 555 timer in astable mode: RC capacitor, threshold/trigger
// comparators, output latch, active-low RESET pin and a period counter
// that reports the spacing of output rising edges in sample ticks.
module astable555_core
  import astable555_pkg::*;
#(
  parameter int W           = VOLT_W,
  parameter int K_CHARGE    = 655,
  parameter int K_DISCHARGE = 1311,
  parameter int CNT_W       = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [W-1:0]     vcc,
  input  logic [W-1:0]     v_control,
  input  logic             reset_pin_n,
  output logic [W-1:0]     square_wave,
  output logic             out_high,
  output logic [W-1:0]     v_cap,
  output logic [CNT_W-1:0] period_ticks,
  output logic             period_valid
);

  localparam logic [15:0]       K_CHG   = 16'(K_CHARGE);
  localparam logic [15:0]       K_DIS   = 16'(K_DISCHARGE);
  localparam logic [31:0]       CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  state_e           state_q;
  logic [W-1:0]     cap_q;
  logic [W-1:0]     cap_d;
  logic [CNT_W-1:0] counter_q;
  logic [CNT_W-1:0] counterInc;
  logic [CNT_W-1:0] periodTicks_q;
  logic             periodValid_q;
  logic             outHigh_q;
  logic             outHigh_d;
  logic [W-1:0]     squareWave_q;
  logic [W-1:0]     capTarget;
  logic [15:0]      capCoeff;
  logic [W-1:0]     trgLevel;
  logic             trigHit;
  logic             thrHit;

  // The cap charges toward vcc only while latched high and RESET is not
  // pulling the discharge transistor on; otherwise it bleeds toward 0.
  always_comb begin
    outHigh_d  = (state_q == CHARGING) && reset_pin_n;
    capTarget  = outHigh_d ? vcc : '0;
    capCoeff   = outHigh_d ? K_CHG : K_DIS;
    counterInc = CNT_W'(sat_add(32'(counter_q), 32'sd1, CNT_MAX));
  end

  rc_step #(
    .W(W)
  ) u_rc_step (
    .target_i  (capTarget),
    .cap_i     (cap_q),
    .k_i       (capCoeff),
    .cap_next_o(cap_d)
  );

  // Comparators look at the cap value this tick is about to produce.
  always_comb begin
    trgLevel = v_control >> 1;
    trigHit  = (cap_d <= trgLevel);
    thrHit   = (cap_d >= v_control);
  end

  // Latch state, capacitor, period counter and the registered output pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= CHARGING;
      cap_q         <= '0;
      counter_q     <= '0;
      periodTicks_q <= '0;
      periodValid_q <= 1'b0;
      outHigh_q     <= 1'b0;
      squareWave_q  <= '0;
    end else begin
      periodValid_q <= 1'b0;
      outHigh_q     <= outHigh_d;
      squareWave_q  <= outHigh_d ? vcc : '0;
      if (!reset_pin_n) begin
        state_q <= DISCHARGING;
        if (ce) begin
          cap_q     <= cap_d;
          counter_q <= counterInc;
        end
      end else if (ce) begin
        cap_q <= cap_d;
        if (trigHit) begin
          state_q <= CHARGING;
        end else if (thrHit) begin
          state_q <= DISCHARGING;
        end
        if ((state_q == DISCHARGING) && trigHit) begin
          periodTicks_q <= counterInc;
          periodValid_q <= 1'b1;
          counter_q     <= '0;
        end else begin
          counter_q <= counterInc;
        end
      end
    end
  end

  assign square_wave  = squareWave_q;
  assign out_high     = outHigh_q;
  assign v_cap        = cap_q;
  assign period_ticks = periodTicks_q;
  assign period_valid = periodValid_q;

endmodule

// File: tb/tb_astable555_core.sv
// Directed bench for astable555_core. u_fast uses K = 0.5 for both
// directions so every cap value is easy to derive by hand; u_sat uses the
// default coefficients to exercise the minimum-step and saturation path.
module tb_astable555_core;

  logic        clk;
  logic        rst;
  logic        ce;
  logic [15:0] vcc;
  logic [15:0] vCtl;
  logic        resetPinN;
  logic [15:0] squareWave;
  logic        outHigh;
  logic [15:0] vCap;
  logic [23:0] periodTicks;
  logic        periodValid;

  logic        satRst;
  logic        satCe;
  logic [15:0] satVcc;
  logic [15:0] satVctl;
  logic        satResetPinN;
  logic [15:0] satSquare;
  logic        satOutHigh;
  logic [15:0] satVCap;
  logic [23:0] satPeriodTicks;
  logic        satPeriodValid;

  int nChecks = 0;
  int nFails  = 0;

  astable555_core #(
    .W(16), .K_CHARGE(32768), .K_DISCHARGE(32768), .CNT_W(24)
  ) u_fast (
    .clk(clk), .rst(rst), .ce(ce), .vcc(vcc), .v_control(vCtl),
    .reset_pin_n(resetPinN), .square_wave(squareWave), .out_high(outHigh),
    .v_cap(vCap), .period_ticks(periodTicks), .period_valid(periodValid)
  );

  astable555_core u_sat (
    .clk(clk), .rst(satRst), .ce(satCe), .vcc(satVcc), .v_control(satVctl),
    .reset_pin_n(satResetPinN), .square_wave(satSquare), .out_high(satOutHigh),
    .v_cap(satVCap), .period_ticks(satPeriodTicks), .period_valid(satPeriodValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Synchronous reset of u_fast with the 5 V / 3.33 V operating point.
  task automatic reset_fast(input logic [15:0] supply, input logic [15:0] ctl);
    rst = 1'b1; ce = 1'b0; resetPinN = 1'b1; vcc = supply; vCtl = ctl;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_fast(16'd20480, 16'd13653);
    nChecks++; if (vCap !== 16'd0) begin nFails++; $display("[TB] FAIL reset_cap: got %0d expected 0", vCap); end
    nChecks++; if (outHigh !== 1'b0) begin nFails++; $display("[TB] FAIL reset_out_high: got %0b expected 0", outHigh); end
    nChecks++; if (squareWave !== 16'd0) begin nFails++; $display("[TB] FAIL reset_square: got %0d expected 0", squareWave); end
    nChecks++; if (periodTicks !== 24'd0) begin nFails++; $display("[TB] FAIL reset_period: got %0d expected 0", periodTicks); end
    nChecks++; if (periodValid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_valid: got %0b expected 0", periodValid); end
  endtask

  // thr = 13653, trg = 6826; cap halves its distance to target each tick.
  task automatic test_oscillation();
    int   expCap [8] = '{10240, 15360, 7680, 3840, 12160, 16320, 8160, 4080};
    logic expOut [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic expPv  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    reset_fast(16'd20480, 16'd13653);
    ce = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      nChecks++; if (vCap !== 16'(expCap[i])) begin nFails++; $display("[TB] FAIL osc_cap[%0d]: got %0d expected %0d", i, vCap, expCap[i]); end
      nChecks++; if (outHigh !== expOut[i]) begin nFails++; $display("[TB] FAIL osc_out_high[%0d]: got %0b expected %0b", i, outHigh, expOut[i]); end
      nChecks++; if (squareWave !== (expOut[i] ? 16'd20480 : 16'd0)) begin nFails++; $display("[TB] FAIL osc_square[%0d]: got %0d expected %0d", i, squareWave, expOut[i] ? 20480 : 0); end
      nChecks++; if (periodValid !== expPv[i]) begin nFails++; $display("[TB] FAIL osc_valid[%0d]: got %0b expected %0b", i, periodValid, expPv[i]); end
      if (expPv[i]) begin
        nChecks++; if (periodTicks !== 24'd4) begin nFails++; $display("[TB] FAIL osc_period[%0d]: got %0d expected 4", i, periodTicks); end
      end
    end
    // With the model frozen the pin still follows a new supply one clk later.
    ce = 1'b0; vcc = 16'd16384;
    step();
    nChecks++; if (squareWave !== 16'd16384) begin nFails++; $display("[TB] FAIL osc_vcc_track: got %0d expected 16384", squareWave); end
    nChecks++; if (vCap !== 16'd4080) begin nFails++; $display("[TB] FAIL osc_hold_cap: got %0d expected 4080", vCap); end
  endtask

  // ce every third clock: same per-tick sequence, everything holds between.
  task automatic test_ce_gating();
    int   expCap   [8] = '{10240, 15360, 7680, 3840, 12160, 16320, 8160, 4080};
    logic expState [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic expPv    [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    reset_fast(16'd20480, 16'd13653);
    for (int i = 0; i < 8; i++) begin
      ce = 1'b1;
      step();
      nChecks++; if (vCap !== 16'(expCap[i])) begin nFails++; $display("[TB] FAIL ce_cap[%0d]: got %0d expected %0d", i, vCap, expCap[i]); end
      nChecks++; if (periodValid !== expPv[i]) begin nFails++; $display("[TB] FAIL ce_valid[%0d]: got %0b expected %0b", i, periodValid, expPv[i]); end
      if (expPv[i]) begin
        nChecks++; if (periodTicks !== 24'd4) begin nFails++; $display("[TB] FAIL ce_period[%0d]: got %0d expected 4", i, periodTicks); end
      end
      ce = 1'b0;
      for (int j = 0; j < 2; j++) begin
        step();
        nChecks++; if (vCap !== 16'(expCap[i])) begin nFails++; $display("[TB] FAIL ce_hold_cap[%0d.%0d]: got %0d expected %0d", i, j, vCap, expCap[i]); end
        nChecks++; if (periodValid !== 1'b0) begin nFails++; $display("[TB] FAIL ce_hold_valid[%0d.%0d]: got %0b expected 0", i, j, periodValid); end
        nChecks++; if (outHigh !== expState[i]) begin nFails++; $display("[TB] FAIL ce_hold_out[%0d.%0d]: got %0b expected %0b", i, j, outHigh, expState[i]); end
      end
    end
  endtask

  // RESET pin pulled low while charging at 10240: output drops on the next
  // clk even with ce low, cap only bleeds on ticks, comparators are ignored
  // (5120 is already below trg), and release restarts from the current cap.
  task automatic test_reset_pin();
    int expCap [3] = '{5120, 2560, 1280};
    reset_fast(16'd20480, 16'd13653);
    ce = 1'b1;
    step();
    resetPinN = 1'b0; ce = 1'b0;
    step();
    nChecks++; if (outHigh !== 1'b0) begin nFails++; $display("[TB] FAIL pin_out_low: got %0b expected 0", outHigh); end
    nChecks++; if (squareWave !== 16'd0) begin nFails++; $display("[TB] FAIL pin_square_low: got %0d expected 0", squareWave); end
    nChecks++; if (vCap !== 16'd10240) begin nFails++; $display("[TB] FAIL pin_cap_hold: got %0d expected 10240", vCap); end
    ce = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      nChecks++; if (vCap !== 16'(expCap[i])) begin nFails++; $display("[TB] FAIL pin_cap[%0d]: got %0d expected %0d", i, vCap, expCap[i]); end
      nChecks++; if (outHigh !== 1'b0) begin nFails++; $display("[TB] FAIL pin_out[%0d]: got %0b expected 0", i, outHigh); end
      nChecks++; if (periodValid !== 1'b0) begin nFails++; $display("[TB] FAIL pin_valid[%0d]: got %0b expected 0", i, periodValid); end
    end
    resetPinN = 1'b1;
    step();
    nChecks++; if (vCap !== 16'd640) begin nFails++; $display("[TB] FAIL pin_release_cap: got %0d expected 640", vCap); end
    nChecks++; if (periodValid !== 1'b1) begin nFails++; $display("[TB] FAIL pin_release_valid: got %0b expected 1", periodValid); end
    nChecks++; if (periodTicks !== 24'd5) begin nFails++; $display("[TB] FAIL pin_release_period: got %0d expected 5", periodTicks); end
    step();
    nChecks++; if (outHigh !== 1'b1) begin nFails++; $display("[TB] FAIL pin_release_out: got %0b expected 1", outHigh); end
    nChecks++; if (vCap !== 16'd10560) begin nFails++; $display("[TB] FAIL pin_recharge_cap: got %0d expected 10560", vCap); end
  endtask

  // v_control = 0 makes cap_next >= thr and cap_next <= trg true together
  // (vcc = 0 keeps cap at 0), so the latch must stay high and never pulse.
  task automatic test_trigger_dominance();
    reset_fast(16'd0, 16'd0);
    ce = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      nChecks++; if (outHigh !== 1'b1) begin nFails++; $display("[TB] FAIL trig_out[%0d]: got %0b expected 1", i, outHigh); end
      nChecks++; if (vCap !== 16'd0) begin nFails++; $display("[TB] FAIL trig_cap[%0d]: got %0d expected 0", i, vCap); end
      nChecks++; if (periodValid !== 1'b0) begin nFails++; $display("[TB] FAIL trig_valid[%0d]: got %0b expected 0", i, periodValid); end
    end
  endtask

  // rst while discharging discards the period; the first edge after it is
  // measured from the reset, so the D->C edge at tick 4 reports 4.
  task automatic test_sync_reset();
    int   expCap [4] = '{10240, 15360, 7680, 3840};
    logic expPv  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    reset_fast(16'd20480, 16'd13653);
    ce = 1'b1;
    for (int i = 0; i < 7; i++) step();
    nChecks++; if (vCap !== 16'd8160) begin nFails++; $display("[TB] FAIL srst_pre_cap: got %0d expected 8160", vCap); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    nChecks++; if (vCap !== 16'd0) begin nFails++; $display("[TB] FAIL srst_cap: got %0d expected 0", vCap); end
    nChecks++; if (outHigh !== 1'b0) begin nFails++; $display("[TB] FAIL srst_out: got %0b expected 0", outHigh); end
    nChecks++; if (squareWave !== 16'd0) begin nFails++; $display("[TB] FAIL srst_square: got %0d expected 0", squareWave); end
    nChecks++; if (periodTicks !== 24'd0) begin nFails++; $display("[TB] FAIL srst_period: got %0d expected 0", periodTicks); end
    for (int i = 0; i < 4; i++) begin
      step();
      nChecks++; if (vCap !== 16'(expCap[i])) begin nFails++; $display("[TB] FAIL srst_cap_seq[%0d]: got %0d expected %0d", i, vCap, expCap[i]); end
      nChecks++; if (periodValid !== expPv[i]) begin nFails++; $display("[TB] FAIL srst_valid[%0d]: got %0b expected %0b", i, periodValid, expPv[i]); end
    end
    nChecks++; if (periodTicks !== 24'd4) begin nFails++; $display("[TB] FAIL srst_period_after: got %0d expected 4", periodTicks); end
  endtask

  // Default K: first step 65535*655>>16 = 654; near the rail the step
  // floors to 0 and is forced to +1; hitting 65535 trips the threshold,
  // then 65535*1311>>16 floors to -1311 giving 64224.
  task automatic test_saturation();
    bit found;
    satRst = 1'b1; satCe = 1'b0; satResetPinN = 1'b1; satVcc = 16'd65535; satVctl = 16'd65535;
    step();
    satRst = 1'b0; satCe = 1'b1;
    step();
    nChecks++; if (satVCap !== 16'd654) begin nFails++; $display("[TB] FAIL sat_first_step: got %0d expected 654", satVCap); end
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      step();
      if (satVCap === 16'd65534) found = 1'b1;
    end
    nChecks++; if (found !== 1'b1) begin nFails++; $display("[TB] FAIL sat_reach_65534: got %0b expected 1", found); end
    nChecks++; if (satOutHigh !== 1'b1) begin nFails++; $display("[TB] FAIL sat_out_before: got %0b expected 1", satOutHigh); end
    step();
    nChecks++; if (satVCap !== 16'd65535) begin nFails++; $display("[TB] FAIL sat_min_step: got %0d expected 65535", satVCap); end
    step();
    nChecks++; if (satVCap !== 16'd64224) begin nFails++; $display("[TB] FAIL sat_discharge: got %0d expected 64224", satVCap); end
    nChecks++; if (satOutHigh !== 1'b0) begin nFails++; $display("[TB] FAIL sat_out_after: got %0b expected 0", satOutHigh); end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; vcc = 16'd0; vCtl = 16'd0; resetPinN = 1'b1;
    satRst = 1'b1; satCe = 1'b0; satVcc = 16'd0; satVctl = 16'd0; satResetPinN = 1'b1;
    $display("[TB] starting astable555_core bench");
    test_reset();
    test_oscillation();
    test_ce_gating();
    test_reset_pin();
    test_trigger_dominance();
    test_sync_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
